fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the control unit (cu).
- Holds the program counter and a loadable instruction memory, and presents one registered instruction per cycle.
- The opcode field drives cu; the register and immediate fields go to the datapath.
- Consumes cu's Branch output and the ALU zero flag to select the next PC.
- Supports a run/halt sequencer, a stall input and a program-load port.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control, program-load port and the registered instruction
// fields. The fetch unit takes the master side.
interface fetch_unit_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 16
);
    logic                   start_i;
    logic                   stall_i;
    logic                   branch_i;
    logic                   zero_i;
    logic                   load_en_i;
    logic [PC_WIDTH-1:0]    load_addr_i;
    logic [INSTR_WIDTH-1:0] load_data_i;
    logic [PC_WIDTH-1:0]    pc_o;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic                   instr_valid_o;
    logic [3:0]             opcode_o;
    logic [3:0]             rd_o;
    logic [3:0]             rs_o;
    logic [7:0]             imm_o;
    logic                   halted_o;

    modport master (
        input  start_i, stall_i, branch_i, zero_i,
        input  load_en_i, load_addr_i, load_data_i,
        output pc_o, instr_o, instr_valid_o,
        output opcode_o, rd_o, rs_o, imm_o, halted_o
    );

    modport slave (
        output start_i, stall_i, branch_i, zero_i,
        output load_en_i, load_addr_i, load_data_i,
        input  pc_o, instr_o, instr_valid_o,
        input  opcode_o, rd_o, rs_o, imm_o, halted_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, loadable instruction memory and a registered
// instruction, with an IDLE/RUN/HALT sequencer, stall and taken-branch select.
module fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 8,
    parameter int unsigned         INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]          HALT_OPCODE = 4'hF
) (
    input logic          clk,
    input logic          rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d, fetch_pc;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d, fetch_data;
    logic                   valid_q, valid_d;
    logic                   halted_q, halted_d;
    logic                   load_we, taken, halt_hit;

    logic [INSTR_WIDTH-1:0] imem [2**PC_WIDTH];

    assign load_we = bus.load_en_i && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (load_we) imem[bus.load_addr_i] <= bus.load_data_i;
    end

    // A load landing on the start address in the start cycle is forwarded,
    // so the first fetch sees the new word.
    assign fetch_data = (load_we && (bus.load_addr_i == fetch_pc))
                        ? bus.load_data_i : imem[fetch_pc];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        fetch_pc = RESET_PC;
        taken    = bus.branch_i && bus.zero_i;
        halt_hit = valid_q && (instr_q[15:12] == HALT_OPCODE);
        case (state_q)
            IDLE, HALT: begin
                if (bus.start_i) begin
                    state_d  = RUN;
                    pc_d     = RESET_PC;
                    instr_d  = fetch_data;
                    valid_d  = 1'b1;
                    halted_d = 1'b0;
                end
            end
            RUN: begin
                if (!bus.stall_i) begin
                    if (halt_hit) begin
                        state_d  = HALT;
                        valid_d  = 1'b0;
                        halted_d = 1'b1;
                    end else begin
                        fetch_pc = taken ? pc_q + PC_WIDTH'($signed(instr_q[7:0]))
                                         : pc_q + PC_WIDTH'(1);
                        pc_d     = fetch_pc;
                        instr_d  = fetch_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.instr_o       = instr_q;
    assign bus.instr_valid_o = valid_q;
    assign bus.halted_o      = halted_q;
    assign bus.opcode_o      = instr_q[15:12];
    assign bus.rd_o          = instr_q[11:8];
    assign bus.rs_o          = instr_q[7:4];
    assign bus.imm_o         = instr_q[7:0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed and random bench for fetch_unit against an arithmetic model of the
// fetch rules (mode, PC, memory array).
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(16)) bus ();

    fetch_unit #(
        .PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00), .HALT_OPCODE(4'hF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // model: mode 0 idle, 1 run, 2 halt
    int          m_mode;
    int          m_pc;
    logic [15:0] m_instr;
    bit          m_valid, m_halted;
    logic [15:0] m_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int w;
        w = int'(m_instr);
        chk({tag, ".pc"},     32'(bus.pc_o),          32'(m_pc));
        chk({tag, ".instr"},  32'(bus.instr_o),       32'(w));
        chk({tag, ".valid"},  32'(bus.instr_valid_o), 32'(m_valid));
        chk({tag, ".halted"}, 32'(bus.halted_o),      32'(m_halted));
        chk({tag, ".opcode"}, 32'(bus.opcode_o),      32'(w / 4096));
        chk({tag, ".rd"},     32'(bus.rd_o),          32'((w / 256) % 16));
        chk({tag, ".rs"},     32'(bus.rs_o),          32'((w / 16) % 16));
        chk({tag, ".imm"},    32'(bus.imm_o),         32'(w % 256));
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = '0; m_valid = 0; m_halted = 0;
    endtask

    task automatic model_step();
        int step;
        if (!rst_n) return;
        if (bus.load_en_i && m_mode != 1) m_mem[bus.load_addr_i] = bus.load_data_i;
        if (m_mode != 1) begin
            if (bus.start_i) begin
                m_mode = 1; m_pc = 0; m_instr = m_mem[0]; m_valid = 1; m_halted = 0;
            end
        end else if (!bus.stall_i) begin
            if (m_valid && (int'(m_instr) / 4096 == 15)) begin
                m_mode = 2; m_valid = 0; m_halted = 1;
            end else begin
                step = 1;
                if (bus.branch_i && bus.zero_i) begin
                    step = int'(m_instr) % 256;
                    if (step >= 128) step -= 256;
                end
                m_pc = (m_pc + step + 256) % 256;
                m_instr = m_mem[m_pc];
            end
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        bus.load_en_i = 1'b1; bus.load_addr_i = addr; bus.load_data_i = data;
        tick("load");
        bus.load_en_i = 1'b0;
    endtask

    task automatic start_run();
        bus.start_i = 1'b1;
        tick("start");
        bus.start_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        bus.start_i = 0; bus.stall_i = 0; bus.branch_i = 0; bus.zero_i = 0;
        bus.load_en_i = 0; bus.load_addr_i = '0; bus.load_data_i = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));

        // sequential fetch, load gating in RUN, restart, load+start write-first
        load(8'h00, 16'h0123); load(8'h01, 16'h1456);
        load(8'h02, 16'h2789); load(8'h03, 16'hF000);
        start_run();
        chk("seq_pc0", 32'(bus.pc_o), 32'h0);
        chk("seq_instr0", 32'(bus.instr_o), 32'h0123);
        chk("seq_valid0", 32'(bus.instr_valid_o), 32'h1);
        bus.load_en_i = 1; bus.load_addr_i = 8'h00; bus.load_data_i = 16'hBEEF;
        tick("run_load");
        bus.load_en_i = 0;
        chk("seq_pc1", 32'(bus.pc_o), 32'h1);
        chk("seq_opcode1", 32'(bus.opcode_o), 32'h1);
        tick("seq2");
        bus.start_i = 1;
        tick("seq3");
        bus.start_i = 0;
        chk("seq_instr3", 32'(bus.instr_o), 32'hF000);
        tick("halt");
        chk("halt_valid", 32'(bus.instr_valid_o), 32'h0);
        chk("halt_flag", 32'(bus.halted_o), 32'h1);
        chk("halt_pc", 32'(bus.pc_o), 32'h3);
        tick("halt_hold");
        start_run();
        chk("load_gated", 32'(bus.instr_o), 32'h0123);
        repeat (4) tick("rerun");
        chk("halt_again", 32'(bus.halted_o), 32'h1);
        bus.load_en_i = 1; bus.load_addr_i = 8'h00; bus.load_data_i = 16'h3AAA;
        start_run();
        bus.load_en_i = 0;
        chk("wfirst_instr", 32'(bus.instr_o), 32'h3AAA);
        chk("wfirst_pc", 32'(bus.pc_o), 32'h0);
        chk("wfirst_halted", 32'(bus.halted_o), 32'h0);
        repeat (4) tick("to_halt");

        // branch taken / not taken at pc 4
        load(8'h03, 16'h0000); load(8'h04, 16'h5404);
        load(8'h05, 16'hF000); load(8'h08, 16'hF000);
        start_run();
        repeat (4) tick("to_pc4");
        chk("br_at4", 32'(bus.pc_o), 32'h4);
        bus.branch_i = 1; bus.zero_i = 1;
        tick("br_taken");
        bus.branch_i = 0; bus.zero_i = 0;
        chk("br_taken_pc", 32'(bus.pc_o), 32'h8);
        tick("br_halt8");
        start_run();
        repeat (4) tick("to_pc4b");
        bus.branch_i = 1; bus.zero_i = 0;
        tick("br_not_taken");
        bus.branch_i = 0;
        chk("br_nt_pc", 32'(bus.pc_o), 32'h5);
        tick("br_halt5");

        // negative offset, wrap, stall over branch and over halt
        load(8'h02, 16'h60FC); load(8'h03, 16'hF000);
        load(8'hFE, 16'h7111); load(8'hFF, 16'h8222);
        start_run();
        tick("w1"); tick("w2");
        bus.branch_i = 1; bus.zero_i = 1;
        tick("neg_br");
        bus.branch_i = 0; bus.zero_i = 0;
        chk("neg_pc", 32'(bus.pc_o), 32'hFE);
        tick("pc_ff");
        chk("pc_ff", 32'(bus.pc_o), 32'hFF);
        bus.stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            bus.branch_i = 1'($urandom); bus.zero_i = 1'($urandom);
            tick("stall");
            chk("stall_pc", 32'(bus.pc_o), 32'hFF);
            chk("stall_instr", 32'(bus.instr_o), 32'h8222);
        end
        bus.stall_i = 0; bus.branch_i = 0; bus.zero_i = 0;
        tick("wrap");
        chk("wrap_pc", 32'(bus.pc_o), 32'h00);
        tick("w3"); tick("w4"); tick("w5");
        bus.stall_i = 1;
        tick("stall_halt1"); tick("stall_halt2");
        chk("stall_halt", 32'(bus.halted_o), 32'h0);
        bus.stall_i = 0;
        tick("halt_after_stall");
        chk("halt_after_stall", 32'(bus.halted_o), 32'h1);

        // asynchronous reset mid-run at pc 5
        load(8'h03, 16'h0000);
        start_run();
        repeat (5) tick("to_pc5");
        chk("pre_rst_pc", 32'(bus.pc_o), 32'h5);
        #2 rst_n = 1'b0; bus.start_i = 1;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_pc", 32'(bus.pc_o), 32'h0);
        tick("rst_held1"); tick("rst_held2");
        bus.start_i = 0;
        @(negedge clk) rst_n = 1'b1;
        tick("post_rst");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.start_i     = ($urandom_range(0, 7) == 0);
            bus.stall_i     = ($urandom_range(0, 3) == 0);
            bus.branch_i    = 1'($urandom);
            bus.zero_i      = 1'($urandom);
            bus.load_en_i   = ($urandom_range(0, 3) == 0);
            bus.load_addr_i = 8'($urandom);
            bus.load_data_i = 16'($urandom);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
